matrix_xif_issue_queue: RTL and testbench
=========================================

# matrix_xif_issue_queue

In-order offload buffer between the CVA6 CV-X-IF port and the matrix accelerator execution pipeline. It accepts or rejects each offered instruction by opcode, captures the source-register operands and tracks commit/kill per entry. It then dispatches committed, non-killed instructions, with operands, to the executor strictly in issue order. Downstream neighbour of the core's coprocessor interface, upstream of the matrix execute/AXI stage.

## Interface
Parameters:
- OPCODE, 7'h2B, major opcode claimed by the accelerator
- ID_WIDTH, 4, CV-X-IF instruction id width
- XLEN, 64, GPR width
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid_i  in  1  core offers instruction
- issue_ready_o  out  1  queue not full
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  instruction id
- issue_accept_o  out  1  opcode matches OPCODE
- issue_writeback_o  out  1  constant 0; accelerator writes no GPR
- issue_register_read_o  out  2  2'b11 when accepted, else 2'b00
- register_valid_i  in  1  operands offered
- register_ready_o  out  1  equals &register_rs_valid_i
- register_id_i  in  ID_WIDTH  operand owner id
- register_rs_i  in  2*XLEN  {rs2, rs1}
- register_rs_valid_i  in  2  per-operand valid
- commit_valid_i  in  1  commit/kill event
- commit_id_i  in  ID_WIDTH  target id
- commit_kill_i  in  1  1 = kill, 0 = commit
- exec_valid_o  out  1  head ready to dispatch
- exec_ready_i  in  1  executor accepts
- exec_instr_o  out  32  head instruction
- exec_id_o  out  ID_WIDTH  head id
- exec_rs1_o / exec_rs2_o  out  XLEN each  head operands
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry fields: valid, instr, id, ops_ok, committed, killed, rs1, rs2. Storage is a circular buffer with head/tail pointers and a count.
- Issue: issue_accept_o = (issue_instr_i[6:0]==OPCODE), combinational.
  - The handshake completes on issue_valid_i & issue_ready_o.
  - An accepted instruction allocates the entry at tail with ops_ok/committed/killed = 0.
  - A rejected instruction allocates nothing.
- Register: on register_valid_i & register_ready_o, the oldest valid entry with id==register_id_i and !ops_ok latches rs1/rs2 and sets ops_ok. No match: the transfer completes and is dropped.
- Commit: on commit_valid_i, the oldest valid entry with id==commit_id_i sets committed, or sets killed if commit_kill_i. No match: ignored. Register and commit to the same entry in the same cycle both take effect.
- Head retire:
  - If head is killed, it is freed without dispatch, one per cycle, regardless of ops_ok.
  - If head is committed & ops_ok & !killed, exec_valid_o=1. The entry is freed on exec_valid_o & exec_ready_i.
- Duplicate ids in flight: matching always selects the oldest. The core guarantees uniqueness; no error is flagged.
- Pointers wrap modulo DEPTH.

## Timing
- All of exec_* and count_o are driven from registered state only. No combinational path from register/commit inputs to exec_valid_o.
- issue_ready_o = (count < DEPTH), using the registered count. A same-cycle head free does not admit an issue when full.
- Minimum latency: issue (cycle 0), register (1), commit (2), exec_valid_o high in cycle 3. Commit before register is legal; dispatch follows the later of the two by one cycle.
- exec_valid_o, once high, stays high with stable payload until exec_ready_i. A kill arriving for a head already presenting exec_valid_o is ignored (the instruction was committed).
- Simultaneous allocate and free: count unchanged, both pointers advance.
- Reset values: count_o=0; exec_valid_o=0; exec_instr_o/exec_id_o/exec_rs*_o=0; all entries invalid.
- issue_ready_o is 1 during and after reset. The register_ready_o and issue_accept_o combinational outputs follow their inputs.
- Reset mid-operation discards all entries in the cycle rst is sampled high, with no dispatch that cycle.

## Structure
- matrix_xif_pkg: entry struct typedef, default OPCODE constant, decode function is_matrix_op(instr).
- Single module; CAM-style id match is a for-loop with oldest-first priority from head. No sub-module needed.

## Test plan
- Offer instr 0x0000_002B id 3, then register rs1=0x10 rs2=0x20 id 3, then commit id 3 → exec_valid_o in cycle 3 with rs1 0x10, rs2 0x20, id 3.
- Offer opcode 7'h33 → issue_accept_o=0, issue_register_read_o=0, count_o stays 0.
- Issue ids 0..3 with exec_ready_i=0 → issue_ready_o=0 at count 4. A fifth offer is stalled; after one dispatch it is accepted next cycle.
- Issue ids 1,2; kill id 1, commit id 2 with operands → id 1 freed silently, id 2 dispatched first.
- Commit arrives before register for id 5 → exec_valid_o one cycle after the register transfer.
- Assert rst with 3 entries pending → count_o=0, exec_valid_o=0 next cycle, queue fully reusable.

Source files
------------

// File: rtl/matrix_xif_pkg.sv
// matrix_xif_pkg
//   Shared definitions for the matrix accelerator CV-X-IF issue queue.
//   - MATRIX_OPCODE : default major opcode claimed by the accelerator
//   - entry_flags_t : per-entry status bits. Payload fields (instr, id, rs1,
//                     rs2) have parameterised widths, so they live in
//                     separate arrays in the queue.
//   - is_matrix_op  : opcode decode used for the accept decision
package matrix_xif_pkg;

  localparam logic [6:0] MATRIX_OPCODE = 7'h2B;

  typedef struct packed {
    logic valid;
    logic ops_ok;
    logic committed;
    logic killed;
  } entry_flags_t;

  function automatic logic is_matrix_op(input logic [31:0] instr,
                                        input logic [6:0]  opcode);
    return instr[6:0] == opcode;
  endfunction

endpackage

// File: rtl/matrix_xif_issue_queue.sv
// matrix_xif_issue_queue
//   In-order offload buffer between the CV-X-IF coprocessor port and the
//   matrix execute pipeline. Accepts instructions by opcode, collects their
//   source operands, tracks commit/kill per entry, and dispatches committed,
//   non-killed instructions in issue order.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   issue_*                       instruction offer / accept handshake
//   register_*                    source operand transfer (tagged by id)
//   commit_*                      commit or kill event (tagged by id)
//   exec_*                        head instruction + operands to executor
//   count_o                       number of occupied entries
module matrix_xif_issue_queue
  import matrix_xif_pkg::*;
#(
  parameter logic [6:0] OPCODE   = MATRIX_OPCODE,
  parameter int         ID_WIDTH = 4,
  parameter int         XLEN     = 64,
  parameter int         DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [31:0]             issue_instr_i,
  input  logic [ID_WIDTH-1:0]     issue_id_i,
  output logic                    issue_accept_o,
  output logic                    issue_writeback_o,
  output logic [1:0]              issue_register_read_o,
  input  logic                    register_valid_i,
  output logic                    register_ready_o,
  input  logic [ID_WIDTH-1:0]     register_id_i,
  input  logic [2*XLEN-1:0]       register_rs_i,
  input  logic [1:0]              register_rs_valid_i,
  input  logic                    commit_valid_i,
  input  logic [ID_WIDTH-1:0]     commit_id_i,
  input  logic                    commit_kill_i,
  output logic                    exec_valid_o,
  input  logic                    exec_ready_i,
  output logic [31:0]             exec_instr_o,
  output logic [ID_WIDTH-1:0]     exec_id_o,
  output logic [XLEN-1:0]         exec_rs1_o,
  output logic [XLEN-1:0]         exec_rs2_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_flags_t          flags_reg [DEPTH];
  logic [31:0]           instr_reg [DEPTH];
  logic [ID_WIDTH-1:0]   id_reg    [DEPTH];
  logic [XLEN-1:0]       rs1_reg   [DEPTH];
  logic [XLEN-1:0]       rs2_reg   [DEPTH];

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;

  entry_flags_t  head_flags;
  logic          alloc;
  logic          reg_fire;
  logic          kill_free;
  logic          dispatch_free;
  logic          free;
  logic          reg_hit;
  logic [PW-1:0] reg_idx;
  logic          cmt_hit;
  logic [PW-1:0] cmt_idx;

  // Issue side: readiness comes from the registered count only, so a head
  // being freed this cycle never lets a full queue take a new instruction.
  assign issue_ready_o         = (count_reg < CW'(DEPTH));
  assign issue_accept_o        = is_matrix_op(issue_instr_i, OPCODE);
  assign issue_writeback_o     = 1'b0;
  assign issue_register_read_o = issue_accept_o ? 2'b11 : 2'b00;
  assign register_ready_o      = &register_rs_valid_i;

  assign alloc    = issue_valid_i & issue_ready_o & issue_accept_o;
  assign reg_fire = register_valid_i & register_ready_o;

  // Head status is purely registered; register/commit inputs only reach the
  // executor one cycle later through the entry flags.
  assign head_flags    = flags_reg[head_reg];
  assign exec_valid_o  = head_flags.valid & head_flags.committed &
                         head_flags.ops_ok & ~head_flags.killed;
  assign kill_free     = head_flags.valid & head_flags.killed;
  assign dispatch_free = exec_valid_o & exec_ready_i;
  assign free          = kill_free | dispatch_free;

  // Payload is masked while nothing is presented so the executor sees zeros
  // out of reset and between dispatches.
  assign exec_instr_o = exec_valid_o ? instr_reg[head_reg] : '0;
  assign exec_id_o    = exec_valid_o ? id_reg[head_reg]    : '0;
  assign exec_rs1_o   = exec_valid_o ? rs1_reg[head_reg]   : '0;
  assign exec_rs2_o   = exec_valid_o ? rs2_reg[head_reg]   : '0;
  assign count_o      = count_reg;

  // Id match, scanning from head so the oldest matching entry wins.
  always_comb begin
    logic [PW-1:0] scan_idx;
    reg_hit  = 1'b0;
    reg_idx  = '0;
    cmt_hit  = 1'b0;
    cmt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_reg + PW'(k);
      if (!reg_hit && flags_reg[scan_idx].valid && !flags_reg[scan_idx].ops_ok &&
          id_reg[scan_idx] == register_id_i) begin
        reg_hit = 1'b1;
        reg_idx = scan_idx;
      end
      if (!cmt_hit && flags_reg[scan_idx].valid &&
          id_reg[scan_idx] == commit_id_i) begin
        cmt_hit = 1'b1;
        cmt_idx = scan_idx;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic is_tail;
      logic is_head;
      logic reg_sel;
      logic cmt_sel;

      assign is_tail = (tail_reg == PW'(gi));
      assign is_head = (head_reg == PW'(gi));
      assign reg_sel = reg_fire & reg_hit & (reg_idx == PW'(gi));
      assign cmt_sel = commit_valid_i & cmt_hit & (cmt_idx == PW'(gi));

      // Allocation only targets an invalid slot (the queue is not full), so
      // it never collides with register/commit updates or a head free.
      always_ff @(posedge clk) begin
        if (rst) begin
          flags_reg[gi] <= '0;
        end else if (alloc && is_tail) begin
          flags_reg[gi] <= '{valid: 1'b1, default: 1'b0};
        end else begin
          if (reg_sel) begin
            flags_reg[gi].ops_ok <= 1'b1;
          end
          if (cmt_sel) begin
            if (!commit_kill_i) begin
              flags_reg[gi].committed <= 1'b1;
            end else if (!(exec_valid_o && is_head)) begin
              // A head already presenting to the executor is committed work.
              flags_reg[gi].killed <= 1'b1;
            end
          end
          if (free && is_head) begin
            flags_reg[gi].valid <= 1'b0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (alloc && is_tail) begin
          instr_reg[gi] <= issue_instr_i;
          id_reg[gi]    <= issue_id_i;
        end
        if (reg_sel) begin
          rs1_reg[gi] <= register_rs_i[XLEN-1:0];
          rs2_reg[gi] <= register_rs_i[2*XLEN-1:XLEN];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg <= head_reg + PW'(free);
      tail_reg <= tail_reg + PW'(alloc);
      case ({alloc, free})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_xif_issue_queue.sv
// tb_matrix_xif_issue_queue
//   Directed scenarios followed by a randomized run. A transaction-level model
//   keeps in-flight instructions in issue order; once an instruction's fate is
//   known (killed, or committed with operands) it is dropped or pushed to the
//   expected-dispatch queue. A separate monitor compares whatever the DUT
//   presents on the exec port against the front of that queue.
module tb_matrix_xif_issue_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid_i;
  logic         issue_ready_o;
  logic [31:0]  issue_instr_i;
  logic [3:0]   issue_id_i;
  logic         issue_accept_o;
  logic         issue_writeback_o;
  logic [1:0]   issue_register_read_o;
  logic         register_valid_i;
  logic         register_ready_o;
  logic [3:0]   register_id_i;
  logic [127:0] register_rs_i;
  logic [1:0]   register_rs_valid_i;
  logic         commit_valid_i;
  logic [3:0]   commit_id_i;
  logic         commit_kill_i;
  logic         exec_valid_o;
  logic         exec_ready_i;
  logic [31:0]  exec_instr_o;
  logic [3:0]   exec_id_o;
  logic [63:0]  exec_rs1_o;
  logic [63:0]  exec_rs2_o;
  logic [2:0]   count_o;

  always #5 clk = ~clk;

  matrix_xif_issue_queue dut (
    .clk                   (clk),
    .rst                   (rst),
    .issue_valid_i         (issue_valid_i),
    .issue_ready_o         (issue_ready_o),
    .issue_instr_i         (issue_instr_i),
    .issue_id_i            (issue_id_i),
    .issue_accept_o        (issue_accept_o),
    .issue_writeback_o     (issue_writeback_o),
    .issue_register_read_o (issue_register_read_o),
    .register_valid_i      (register_valid_i),
    .register_ready_o      (register_ready_o),
    .register_id_i         (register_id_i),
    .register_rs_i         (register_rs_i),
    .register_rs_valid_i   (register_rs_valid_i),
    .commit_valid_i        (commit_valid_i),
    .commit_id_i           (commit_id_i),
    .commit_kill_i         (commit_kill_i),
    .exec_valid_o          (exec_valid_o),
    .exec_ready_i          (exec_ready_i),
    .exec_instr_o          (exec_instr_o),
    .exec_id_o             (exec_id_o),
    .exec_rs1_o            (exec_rs1_o),
    .exec_rs2_o            (exec_rs2_o),
    .count_o               (count_o)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    bit          ops;
    bit          cmt;
    bit          kil;
  } ment_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } disp_t;

  ment_t mq[$];
  disp_t exq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drop killed instructions and hand ready ones to the expected queue, in order.
  task automatic retire();
    disp_t d;
    while (mq.size() > 0 && (mq[0].kil || (mq[0].cmt && mq[0].ops))) begin
      if (!mq[0].kil) begin
        d.id = mq[0].id; d.instr = mq[0].instr; d.rs1 = mq[0].rs1; d.rs2 = mq[0].rs2;
        exq.push_back(d);
      end
      void'(mq.pop_front());
    end
  endtask

  task automatic drive(input bit iv, input logic [31:0] instr, input logic [3:0] iid,
                       input bit rv, input logic [3:0] rid, input logic [63:0] r1,
                       input logic [63:0] r2, input logic [1:0] rsv,
                       input bit cv, input logic [3:0] cid, input bit ck,
                       input bit er, output bit fired);
    bit    acc;
    ment_t m;
    @(posedge clk); #1;
    issue_valid_i = iv; issue_instr_i = instr; issue_id_i = iid;
    register_valid_i = rv; register_id_i = rid; register_rs_i = {r2, r1};
    register_rs_valid_i = rsv;
    commit_valid_i = cv; commit_id_i = cid; commit_kill_i = ck;
    exec_ready_i = er;
    @(negedge clk);
    fired = 1'b0;
    if (rv) begin
      chk("register_ready", 64'(register_ready_o), 64'(&rsv));
      if (&rsv) begin
        foreach (mq[i]) begin
          if (mq[i].id == rid && !mq[i].ops) begin
            mq[i].ops = 1'b1; mq[i].rs1 = r1; mq[i].rs2 = r2;
            break;
          end
        end
      end
    end
    if (cv) begin
      foreach (mq[i]) begin
        if (mq[i].id == cid && !mq[i].cmt && !mq[i].kil) begin
          if (ck) mq[i].kil = 1'b1; else mq[i].cmt = 1'b1;
          break;
        end
      end
    end
    if (iv) begin
      acc = (instr[6:0] == 7'h2B);
      chk("issue_accept", 64'(issue_accept_o), 64'(acc));
      chk("issue_register_read", 64'(issue_register_read_o), acc ? 64'd3 : 64'd0);
      if (issue_ready_o) begin
        fired = 1'b1;
        $display("issue id=%0d instr=0x%08h accept=%0d", iid, instr, acc);
        if (acc) begin
          m.id = iid; m.instr = instr; m.rs1 = '0; m.rs2 = '0;
          m.ops = 1'b0; m.cmt = 1'b0; m.kil = 1'b0;
          mq.push_back(m);
        end
      end
    end
    retire();
  endtask

  task automatic idle(input bit er);
    bit f;
    drive(0, '0, '0, 0, '0, '0, '0, 2'b00, 0, '0, 0, er, f);
  endtask

  task automatic issue(input logic [3:0] id, input bit er);
    bit f;
    drive(1, {21'(id) + 21'h1A5, 4'h0, 7'h2B}, id, 0, '0, '0, '0, 2'b00, 0, '0, 0, er, f);
  endtask

  task automatic regcmt(input bit rv, input bit cv, input bit ck, input logic [3:0] id,
                        input logic [63:0] r1, input logic [63:0] r2, input bit er);
    bit f;
    drive(0, '0, '0, rv, id, r1, r2, 2'b11, cv, id, ck, er, f);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    issue_valid_i = 0; register_valid_i = 0; commit_valid_i = 0; exec_ready_i = 0;
    mq.delete(); exq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int  n;
    bit  done;
    done = 1'b0;
    for (n = 0; n < 200 && !done; n++) begin
      if (mq.size() > 0) begin
        regcmt(!mq[0].ops, !mq[0].cmt && !mq[0].kil, 0, mq[0].id,
               {$urandom, $urandom}, {$urandom, $urandom}, 1);
      end else begin
        idle(1);
      end
      done = (mq.size() == 0 && exq.size() == 0 && count_o == 3'd0);
    end
    chk({name, "_count"}, 64'(count_o), 64'd0);
    chk({name, "_pending"}, 64'(exq.size()), 64'd0);
  endtask

  // Monitor: every presented head must be the front expected dispatch.
  always @(negedge clk) begin
    if (!rst && exec_valid_o) begin
      if (exq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dispatch: got id %0d expected nothing", exec_id_o);
      end else begin
        chk("exec_id", 64'(exec_id_o), 64'(exq[0].id));
        chk("exec_instr", 64'(exec_instr_o), 64'(exq[0].instr));
        chk("exec_rs1", exec_rs1_o, exq[0].rs1);
        chk("exec_rs2", exec_rs2_o, exq[0].rs2);
        if (exec_ready_i) begin
          $display("dispatch id=%0d instr=0x%08h rs1=0x%0h rs2=0x%0h",
                   exec_id_o, exec_instr_o, exec_rs1_o, exec_rs2_o);
          void'(exq.pop_front());
        end
      end
    end
  end

  initial begin
    bit          f;
    int          seq;
    int          q[$];
    int          pick;
    logic [6:0]  op;
    bit          iv, rv, cv, ck;
    logic [3:0]  rid, cid;
    logic [1:0]  rsv;

    rst = 1'b1;
    issue_valid_i = 0; issue_instr_i = '0; issue_id_i = '0;
    register_valid_i = 0; register_id_i = '0; register_rs_i = '0; register_rs_valid_i = '0;
    commit_valid_i = 0; commit_id_i = '0; commit_kill_i = 0; exec_ready_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 64'(issue_ready_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_count", 64'(count_o), 64'd0);
    chk("reset_exec_valid", 64'(exec_valid_o), 64'd0);
    chk("reset_ready", 64'(issue_ready_o), 64'd1);
    chk("reset_writeback", 64'(issue_writeback_o), 64'd0);
    chk("reset_payload", 64'({exec_instr_o, exec_id_o}) | exec_rs1_o | exec_rs2_o, 64'd0);

    // Minimum latency: issue, register, commit, present in cycle 3.
    drive(1, 32'h0000_002B, 4'd3, 0, '0, '0, '0, 2'b00, 0, '0, 0, 0, f);
    regcmt(1, 0, 0, 4'd3, 64'h10, 64'h20, 0);
    regcmt(0, 1, 0, 4'd3, '0, '0, 0);
    chk("latency_not_early", 64'(exec_valid_o), 64'd0);
    idle(0);
    chk("latency_cycle3", 64'(exec_valid_o), 64'd1);
    chk("latency_rs1", exec_rs1_o, 64'h10);
    idle(1);
    drain("latency");

    // Rejected opcode: handshake only, nothing allocated.
    drive(1, 32'h0000_0033, 4'd6, 0, '0, '0, '0, 2'b00, 0, '0, 0, 0, f);
    chk("reject_fired", 64'(f), 64'd1);
    idle(0);
    chk("reject_count", 64'(count_o), 64'd0);

    // Full queue stalls the fifth offer until one dispatch frees a slot.
    for (int i = 0; i < 4; i++) issue(4'(i), 0);
    idle(0);
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(issue_ready_o), 64'd0);
    drive(1, 32'h0000_042B, 4'd4, 1, 4'd0, 64'hA0, 64'hB0, 2'b11, 1, 4'd0, 0, 1, f);
    chk("full_stalled", 64'(f), 64'd0);
    begin
      int n;
      f = 1'b0;
      for (n = 0; n < 8 && !f; n++)
        drive(1, 32'h0000_042B, 4'd4, 0, '0, '0, '0, 2'b00, 0, '0, 0, 1, f);
      chk("full_accept_after_dispatch", 64'(f), 64'd1);
      chk("full_accept_cycles", 64'(n), 64'd2);
    end
    drain("full");

    // Kill older id 1, commit id 2: only id 2 is dispatched.
    issue(4'd1, 0);
    issue(4'd2, 0);
    regcmt(0, 1, 1, 4'd1, '0, '0, 0);
    regcmt(1, 1, 0, 4'd2, 64'h22, 64'h33, 0);
    drain("kill");

    // Commit ahead of operands: present one cycle after the register transfer.
    issue(4'd5, 0);
    regcmt(0, 1, 0, 4'd5, '0, '0, 0);
    idle(0);
    chk("cbr_wait_ops", 64'(exec_valid_o), 64'd0);
    regcmt(1, 0, 0, 4'd5, 64'h55, 64'h66, 0);
    chk("cbr_not_same_cycle", 64'(exec_valid_o), 64'd0);
    idle(0);
    chk("cbr_present", 64'(exec_valid_o), 64'd1);
    drain("cbr");

    // Reset with three entries pending (one presenting), then full reuse.
    issue(4'd7, 0);
    issue(4'd8, 0);
    issue(4'd9, 0);
    regcmt(1, 1, 0, 4'd7, 64'h77, 64'h78, 0);
    do_reset();
    chk("midreset_count", 64'(count_o), 64'd0);
    chk("midreset_exec_valid", 64'(exec_valid_o), 64'd0);
    chk("midreset_ready", 64'(issue_ready_o), 64'd1);
    for (int i = 0; i < 4; i++) issue(4'(i + 7), 0);
    idle(0);
    chk("reuse_full_count", 64'(count_o), 64'd4);
    drain("reuse");

    // Randomized traffic.
    do_reset();
    seq = 0;
    for (int c = 0; c < 600; c++) begin
      iv = ($urandom % 3) != 0;
      op = (($urandom % 5) != 0) ? 7'h2B : 7'($urandom);
      if (op == 7'h2B && ($urandom % 5) == 0) op = 7'h33;
      rv = 0; cv = 0; ck = 0; rid = '0; cid = '0; rsv = 2'b00;
      q.delete();
      foreach (mq[i]) if (!mq[i].ops) q.push_back(i);
      if (q.size() > 0 && ($urandom % 2) == 0) begin
        pick = q[$urandom_range(0, q.size() - 1)];
        rv = 1; rid = mq[pick].id;
        rsv = (($urandom % 5) == 0) ? 2'b01 : 2'b11;
      end
      q.delete();
      foreach (mq[i]) if (!mq[i].cmt && !mq[i].kil) q.push_back(i);
      if (q.size() > 0 && ($urandom % 2) == 0) begin
        pick = q[$urandom_range(0, q.size() - 1)];
        cv = 1; cid = mq[pick].id; ck = ($urandom % 4) == 0;
      end
      drive(iv, {$urandom_range(0, 32'h1FF_FFFF) & 25'h1FF_FFFF, op}, 4'(seq),
            rv, rid, {$urandom, $urandom}, {$urandom, $urandom}, rsv,
            cv, cid, ck, ($urandom % 4) != 0, f);
      if (f && op == 7'h2B) seq++;
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
